// File: rtl/powlib_sfifo_lvl.sv
// Synchronous first-word-fall-through FIFO with level flags and optional high-water mark.
// Define POWLIB_SFIFO_HWM_EN to build the hwm register; otherwise hwm is tied to zero.
module powlib_sfifo_lvl #(
    parameter int unsigned W      = 16,
    parameter int unsigned D      = 8,
    parameter int unsigned AFULL  = D - 1,
    parameter int unsigned AEMPTY = 1,
    parameter int unsigned EDBG   = 0,
    parameter string       ID     = "SFIFO_LVL",
    localparam int unsigned CW    = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  wrdata,
    input  logic          wrvld,
    output logic          wrrdy,
    output logic [W-1:0]  rddata,
    output logic          rdvld,
    input  logic          rdrdy,
    input  logic          flush,
    output logic [CW-1:0] cnt,
    output logic          afull,
    output logic          aempty,
    output logic [CW-1:0] hwm
);

    function automatic int unsigned powlib_clogb2(input int unsigned value);
        int unsigned r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    localparam int unsigned WPTR = powlib_clogb2(D);
    localparam logic [CW-1:0] FULL_C   = CW'(D);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY);

    // Explicit wrap so non-power-of-2 depths never address past the last entry.
    function automatic logic [WPTR-1:0] ptr_inc(input logic [WPTR-1:0] p);
        return (p == WPTR'(D - 1)) ? '0 : p + WPTR'(1);
    endfunction

    logic [W-1:0]    mem [D];
    logic [WPTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [WPTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en, rd_en;

    assign wrrdy  = (cnt_q != FULL_C) && !flush;
    assign rdvld  = (cnt_q != '0) && !flush;
    assign wr_en  = wrvld && wrrdy;
    assign rd_en  = rdvld && rdrdy;
    assign rddata = mem[rd_ptr_q];
    assign cnt    = cnt_q;
    assign afull  = (cnt_q >= AFULL_C);
    assign aempty = (cnt_q <= AEMPTY_C);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_en && !rd_en) begin
                cnt_d = cnt_q + CW'(1);
            end else if (rd_en && !wr_en) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never reset or flushed; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wrdata;
    end

`ifdef POWLIB_SFIFO_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush) begin
            hwm_d = '0;
        end else if (cnt_d > hwm_q) begin
            hwm_d = cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hwm_q <= '0;
        else     hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

`ifndef SYNTHESIS
    if (EDBG != 0) begin : g_dbg
        initial begin
            if (D < 2) begin
                $display("%s: illegal D=%0d", ID, D);
                $finish;
            end
            if (AFULL < 1 || AFULL > D) begin
                $display("%s: illegal AFULL=%0d", ID, AFULL);
                $finish;
            end
            if (AEMPTY > D - 1) begin
                $display("%s: illegal AEMPTY=%0d", ID, AEMPTY);
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_powlib_sfifo_lvl.sv
// Directed bench for powlib_sfifo_lvl (W=8, D=5, AFULL=4, AEMPTY=1).
module tb_powlib_sfifo_lvl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wrdata;
    logic       wrvld;
    logic       wrrdy;
    logic [7:0] rddata;
    logic       rdvld;
    logic       rdrdy;
    logic       flush;
    logic [2:0] cnt;
    logic       afull;
    logic       aempty;
    logic [2:0] hwm;

    int total = 0;
    int bad   = 0;

    powlib_sfifo_lvl #(
        .W(8), .D(5), .AFULL(4), .AEMPTY(1), .EDBG(1), .ID("TB_FIFO")
    ) dut (
        .clk(clk), .rst(rst), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
        .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy), .flush(flush),
        .cnt(cnt), .afull(afull), .aempty(aempty), .hwm(hwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] hwm_exp(input int v);
`ifdef POWLIB_SFIFO_HWM_EN
        return v;
`else
        return 0;
`endif
    endfunction

    initial begin
        rst = 1'b1; wrdata = '0; wrvld = 1'b0; rdrdy = 1'b0; flush = 1'b0;
        #3;
        check("rst_cnt", cnt, 0);
        check("rst_rdvld", rdvld, 0);
        check("rst_wrrdy", wrrdy, 1);
        check("rst_aempty", aempty, 1);
        check("rst_afull", afull, 0);
        check("rst_hwm", hwm, 0);
        rst = 1'b0;
        tick();

        // Fill
        for (int i = 0; i < 5; i++) begin
            wrvld = 1'b1; wrdata = 8'h10 + 8'(i);
            tick();
            check("fill_cnt", cnt, i + 1);
            check("fill_afull", afull, (i + 1 >= 4) ? 1 : 0);
            check("fill_wrrdy", wrrdy, (i + 1 == 5) ? 0 : 1);
        end
        wrdata = 8'h15;
        tick();
        wrvld = 1'b0;
        check("full_no_write", cnt, 5);
        check("full_head", rddata, 8'h10);
        check("fill_hwm", hwm, hwm_exp(5));

        // Drain
        rdrdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_rdvld", rdvld, 1);
            check("drain_data", rddata, 8'h10 + i);
            check("drain_aempty", aempty, (5 - i <= 1) ? 1 : 0);
            tick();
        end
        rdrdy = 1'b0;
        check("drain_cnt", cnt, 0);
        check("drain_rdvld0", rdvld, 0);

        // Wrap: pointers continue past entry 4
        for (int i = 0; i < 7; i++) begin
            wrvld = 1'b1; wrdata = 8'h20 + 8'(i);
            check("wrap_empty_rdvld", rdvld, 0);
            tick();
            wrvld = 1'b0;
            check("wrap_rdvld", rdvld, 1);
            check("wrap_data", rddata, 8'h20 + i);
            check("wrap_aempty", aempty, 1);
            rdrdy = 1'b1;
            tick();
            rdrdy = 1'b0;
            check("wrap_cnt", cnt, 0);
        end

        // Steady state at cnt=3
        for (int i = 0; i < 3; i++) begin
            wrvld = 1'b1; wrdata = 8'h30 + 8'(i);
            tick();
        end
        rdrdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wrdata = 8'h33 + 8'(i);
            check("steady_data", rddata, 8'h30 + i);
            tick();
            check("steady_cnt", cnt, 3);
        end
        rdrdy = 1'b0;
        wrdata = 8'h3D;
        tick();
        check("pre_flush_cnt", cnt, 4);
        check("pre_flush_head", rddata, 8'h3A);

        // Flush with a concurrent write
        flush = 1'b1; wrdata = 8'h99;
        #1;
        check("flush_wrrdy", wrrdy, 0);
        check("flush_rdvld", rdvld, 0);
        tick();
        flush = 1'b0;
        check("flush_cnt", cnt, 0);
        check("flush_hwm", hwm, 0);
        wrdata = 8'hAA;
        tick();
        wrvld = 1'b0;
        check("post_flush_rdvld", rdvld, 1);
        check("post_flush_data", rddata, 8'hAA);
        check("post_flush_cnt", cnt, 1);

        // Async reset mid-cycle with cnt=3
        wrvld = 1'b1; wrdata = 8'hAB;
        tick();
        wrdata = 8'hAC;
        tick();
        wrvld = 1'b0;
        check("pre_rst_cnt", cnt, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cnt", cnt, 0);
        check("arst_rdvld", rdvld, 0);
        check("arst_wrrdy", wrrdy, 1);
        check("arst_hwm", hwm, 0);
        rst = 1'b0;
        tick();
        wrvld = 1'b1; wrdata = 8'hC0;
        tick();
        wrvld = 1'b0;
        check("post_rst_data", rddata, 8'hC0);
        check("post_rst_cnt", cnt, 1);
        rdrdy = 1'b1;
        tick();
        rdrdy = 1'b0;

        // High-water mark: write 4, read 3, write 1
        wrvld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wrdata = 8'h50 + 8'(i);
            tick();
        end
        wrvld = 1'b0;
        check("hwm_after_w4", hwm, hwm_exp(4));
        rdrdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rdrdy = 1'b0;
        wrvld = 1'b1; wrdata = 8'h54;
        tick();
        wrvld = 1'b0;
        check("hwm_cnt", cnt, 2);
        check("hwm_peak", hwm, hwm_exp(4));
        check("hwm_head", rddata, 8'h53);
        check("hwm_aempty", aempty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
